// File: rtl/block_put.sv
// Tile writer: stores a J x K tile into a row-major matrix memory at a (row, col) origin,
// clipping elements that fall outside the matrix, with optional read-add-write accumulation.
module block_put #(
    parameter int DATA_W = 16,
    parameter int J      = 2,
    parameter int K      = 2,
    parameter int IDX_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    accumulate,
    input  logic [IDX_W-1:0]        start_row,
    input  logic [IDX_W-1:0]        start_col,
    input  logic [IDX_W-1:0]        num_cols,
    input  logic [IDX_W-1:0]        matrix_len,
    input  logic [DATA_W*J*K-1:0]   block,
    output logic [IDX_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    busy,
    output logic                    done
);

    localparam int N   = J * K;
    localparam int E_W = (N > 1) ? $clog2(N) : 1;
    localparam int AW  = 2 * IDX_W;
    localparam logic [E_W-1:0] LAST_E = E_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RMW   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [E_W-1:0]         e;
    logic [DATA_W*N-1:0]    blk_q;
    logic [IDX_W-1:0]       row_q;
    logic [IDX_W-1:0]       col_q;
    logic [IDX_W-1:0]       ncols_q;
    logic [IDX_W-1:0]       mlen_q;
    logic                   acc_q;

    logic [AW-1:0]          row_w;
    logic [AW-1:0]          col_w;
    logic [AW-1:0]          addr_w;
    logic                   in_bounds;
    logic [DATA_W-1:0]      elem;

    // Element geometry is evaluated at double width so the bound checks never see a wrapped address.
    always_comb begin
        row_w     = AW'(row_q) + AW'(int'(e) / K);
        col_w     = AW'(col_q) + AW'(int'(e) % K);
        addr_w    = row_w * AW'(ncols_q) + col_w;
        in_bounds = (col_w < AW'(ncols_q)) && (addr_w < AW'(mlen_q));
        elem      = blk_q[int'(e)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            e       <= '0;
            blk_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ncols_q <= '0;
            mlen_q  <= '0;
            acc_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        blk_q   <= block;
                        row_q   <= start_row;
                        col_q   <= start_col;
                        ncols_q <= num_cols;
                        mlen_q  <= matrix_len;
                        acc_q   <= accumulate;
                        e       <= '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (in_bounds && acc_q) begin
                        state <= RMW;
                    end else if (e == LAST_E) begin
                        state <= DONE;
                    end else begin
                        e     <= e + 1'b1;
                        state <= ISSUE;
                    end
                end
                RMW: begin
                    if (e == LAST_E) begin
                        state <= DONE;
                    end else begin
                        e     <= e + 1'b1;
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    e     <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are a pure function of state and element index; RMW data folds in the read returned this cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ISSUE: begin
                busy = 1'b1;
                if (in_bounds) begin
                    mem_addr = addr_w[IDX_W-1:0];
                    if (acc_q) begin
                        mem_re = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_wdata = elem;
                    end
                end
            end
            RMW: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_w[IDX_W-1:0];
                mem_wdata = mem_rdata + elem;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_block_put.sv
// Directed bench for block_put: per-cycle strobe/handshake checks against hand-computed tables
// plus final memory contents for the accumulate cases.
module tb_block_put;

    logic        clk;
    logic        rst;
    logic        start;
    logic        accumulate;
    logic [9:0]  start_row;
    logic [9:0]  start_col;
    logic [9:0]  num_cols;
    logic [9:0]  matrix_len;
    logic [63:0] block;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:15];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [15:0] pre_data;

    int total;
    int bad;
    int cyc;

    block_put #(.DATA_W(16), .J(2), .K(2), .IDX_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .start_row(start_row), .start_col(start_col), .num_cols(num_cols),
        .matrix_len(matrix_len), .block(block), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with one-cycle read latency; bench preload port shares the write path.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr[3:0]] <= pre_data;
        end else if (mem_we && mem_addr < 10'd16) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
        if (mem_re && mem_addr < 10'd16) mem_rdata <= mem[mem_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic launch(input logic acc, input logic [9:0] r, input logic [9:0] c, input logic [63:0] b);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1; accumulate = acc;
        start_row = r; start_col = c; num_cols = 10'd5; matrix_len = 10'd10; block = b;
        cyc = 0;
        @(negedge clk);
        chk("accept_busy", 32'(busy), 32'd0);
        chk("accept_done", 32'(done), 32'd0);
        chk("accept_we", 32'(mem_we), 32'd0);
    endtask

    // One cycle after the previous one: drive start/rst, scramble other inputs, then check outputs.
    task automatic step(input logic st, input logic r, input logic we, input logic re,
                        input logic [9:0] addr, input logic [15:0] wd, input logic bz, input logic dn,
                        input string tag);
        @(posedge clk); #1;
        start = st; rst = r;
        if (!st) begin
            accumulate = 1'($urandom_range(0, 1));
            start_row  = 10'($urandom_range(0, 1023));
            start_col  = 10'($urandom_range(0, 1023));
            num_cols   = 10'($urandom_range(0, 1023));
            matrix_len = 10'($urandom_range(0, 1023));
            block      = {$urandom, $urandom};
        end
        cyc++;
        @(negedge clk);
        chk({tag, "_we"}, 32'(mem_we), 32'(we));
        chk({tag, "_re"}, 32'(mem_re), 32'(re));
        chk({tag, "_busy"}, 32'(busy), 32'(bz));
        chk({tag, "_done"}, 32'(done), 32'(dn));
        if (we || re) chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        if (we) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(wd));
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; accumulate = 1'b0;
        start_row = '0; start_col = '0; num_cols = 10'd5; matrix_len = 10'd10; block = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = 16'd0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_re", 32'(mem_re), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Overwrite at (0,0)
        launch(1'b0, 10'd0, 10'd0, {16'd4, 16'd3, 16'd2, 16'd1});
        step(0, 0, 1, 0, 10'd0, 16'd1, 1, 0, "ow_c1");
        step(0, 0, 1, 0, 10'd1, 16'd2, 1, 0, "ow_c2");
        step(0, 0, 1, 0, 10'd5, 16'd3, 1, 0, "ow_c3");
        step(0, 0, 1, 0, 10'd6, 16'd4, 1, 0, "ow_c4");
        step(0, 0, 0, 0, 10'd0, 16'd0, 0, 1, "ow_c5");
        step(0, 0, 0, 0, 10'd0, 16'd0, 0, 0, "ow_c6");
        chk("ow_mem0", 32'(mem[0]), 32'd1);
        chk("ow_mem6", 32'(mem[6]), 32'd4);

        // Accumulate at (0,2)
        preload(10'd2, 16'd10);
        preload(10'd3, 16'd20);
        preload(10'd7, 16'd30);
        preload(10'd8, 16'd40);
        launch(1'b1, 10'd0, 10'd2, {16'd4, 16'd3, 16'd2, 16'd1});
        step(0, 0, 0, 1, 10'd2, 16'd0, 1, 0, "acc_c1");
        step(0, 0, 1, 0, 10'd2, 16'd11, 1, 0, "acc_c2");
        step(0, 0, 0, 1, 10'd3, 16'd0, 1, 0, "acc_c3");
        step(0, 0, 1, 0, 10'd3, 16'd22, 1, 0, "acc_c4");
        step(0, 0, 0, 1, 10'd7, 16'd0, 1, 0, "acc_c5");
        step(0, 0, 1, 0, 10'd7, 16'd33, 1, 0, "acc_c6");
        step(0, 0, 0, 1, 10'd8, 16'd0, 1, 0, "acc_c7");
        step(0, 0, 1, 0, 10'd8, 16'd44, 1, 0, "acc_c8");
        step(0, 0, 0, 0, 10'd0, 16'd0, 0, 1, "acc_c9");
        @(negedge clk);
        chk("acc_mem2", 32'(mem[2]), 32'd11);
        chk("acc_mem3", 32'(mem[3]), 32'd22);
        chk("acc_mem7", 32'(mem[7]), 32'd33);
        chk("acc_mem8", 32'(mem[8]), 32'd44);

        // Column clip at (0,4)
        launch(1'b0, 10'd0, 10'd4, {16'd8, 16'd7, 16'd6, 16'd5});
        step(0, 0, 1, 0, 10'd4, 16'd5, 1, 0, "clip_c1");
        step(0, 0, 0, 0, 10'd0, 16'd0, 1, 0, "clip_c2");
        step(0, 0, 1, 0, 10'd9, 16'd7, 1, 0, "clip_c3");
        step(0, 0, 0, 0, 10'd0, 16'd0, 1, 0, "clip_c4");
        step(0, 0, 0, 0, 10'd0, 16'd0, 0, 1, "clip_c5");

        // Row clip with wrap-around add at (1,0)
        preload(10'd5, 16'hFFFF);
        preload(10'd6, 16'd0);
        launch(1'b1, 10'd1, 10'd0, {16'd9, 16'd9, 16'd1, 16'd2});
        step(0, 0, 0, 1, 10'd5, 16'd0, 1, 0, "row_c1");
        step(0, 0, 1, 0, 10'd5, 16'h0001, 1, 0, "row_c2");
        step(0, 0, 0, 1, 10'd6, 16'd0, 1, 0, "row_c3");
        step(0, 0, 1, 0, 10'd6, 16'd1, 1, 0, "row_c4");
        step(0, 0, 0, 0, 10'd0, 16'd0, 1, 0, "row_c5");
        step(0, 0, 0, 0, 10'd0, 16'd0, 1, 0, "row_c6");
        step(0, 0, 0, 0, 10'd0, 16'd0, 0, 1, "row_c7");
        @(negedge clk);
        chk("row_mem5", 32'(mem[5]), 32'h0001);
        chk("row_mem6", 32'(mem[6]), 32'd1);

        // Start while busy is ignored; reset mid-operation aborts with no done
        launch(1'b0, 10'd0, 10'd0, {16'd4, 16'd3, 16'd2, 16'd1});
        step(0, 0, 1, 0, 10'd0, 16'd1, 1, 0, "rst_c1");
        step(1, 0, 1, 0, 10'd1, 16'd2, 1, 0, "rst_c2");
        step(0, 1, 1, 0, 10'd5, 16'd3, 1, 0, "rst_c3");
        step(0, 0, 0, 0, 10'd0, 16'd0, 0, 0, "rst_c4");
        step(0, 0, 0, 0, 10'd0, 16'd0, 0, 0, "rst_c5");
        step(0, 0, 0, 0, 10'd0, 16'd0, 0, 0, "rst_c6");

        // Fresh start after the abort
        launch(1'b0, 10'd0, 10'd1, {16'hD, 16'hC, 16'hB, 16'hA});
        step(0, 0, 1, 0, 10'd1, 16'hA, 1, 0, "fresh_c1");
        step(0, 0, 1, 0, 10'd2, 16'hB, 1, 0, "fresh_c2");
        step(0, 0, 1, 0, 10'd6, 16'hC, 1, 0, "fresh_c3");
        step(0, 0, 1, 0, 10'd7, 16'hD, 1, 0, "fresh_c4");
        step(0, 0, 0, 0, 10'd0, 16'd0, 0, 1, "fresh_c5");
        step(0, 0, 0, 0, 10'd0, 16'd0, 0, 0, "fresh_c6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
